// File: rtl/lap_memory.sv
// Circular lap-time store: captures the time word on a save press, browses laps newest-to-oldest.
// Define LAP_SPLIT_EN to build the split-time output (second read port plus subtractor).
module lap_memory #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 8,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             active,
    input  logic [1:0]       KEY,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] lap_out,
    output logic [WIDTH-1:0] split_out,
    output logic [CW-1:0]    view_idx,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             saved
);
    localparam int PW = $clog2(DEPTH);

    logic [1:0]       r_key_s1;
    logic [1:0]       r_key_s2;
    logic [1:0]       r_key_prev;
    logic [1:0]       r_armed;
    logic [1:0]       r_vld;
    logic [1:0]       r_ev;
    logic [1:0]       w_press;
    logic             w_save;
    logic             w_browse;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    w_wr_ptr_nxt;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_nxt;
    logic [CW-1:0]    r_view;
    logic [CW-1:0]    w_view_nxt;
    logic             r_full;
    logic             r_saved;
    logic [PW-1:0]    w_slot;
    logic [WIDTH-1:0] r_lap;
    logic [WIDTH-1:0] r_split;
    logic [WIDTH-1:0] r_mem [DEPTH];

    // Physical slot of view index v: (ptr - 1 - v) mod DEPTH, valid for any DEPTH.
    function automatic logic [PW-1:0] f_slot(input logic [PW-1:0] ptr, input logic [CW-1:0] v);
        logic [CW:0] s;
        s = (CW + 1)'(ptr) + (CW + 1)'(DEPTH - 1) - (CW + 1)'(v);
        if (s >= (CW + 1)'(DEPTH)) begin
            s = s - (CW + 1)'(DEPTH);
        end else begin
            s = s;
        end
        return PW'(s);
    endfunction

    // Button synchroniser, previous-value stage and registered press events.
    // A key only arms once it has been seen released after reset, so a button
    // held through reset release cannot fire.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_key_s1   <= 2'b11;
            r_key_s2   <= 2'b11;
            r_key_prev <= 2'b11;
            r_armed    <= 2'b00;
            r_vld      <= 2'b00;
            r_ev       <= 2'b00;
        end else begin
            r_key_s1   <= KEY;
            r_key_s2   <= r_key_s1;
            r_key_prev <= r_key_s2;
            r_vld      <= {r_vld[0], 1'b1};
            r_armed    <= r_armed | (r_key_s2 & {2{r_vld[1]}});
            r_ev       <= w_press;
        end
    end

    assign w_press = r_armed & r_key_prev & ~r_key_s2;

    // Next-state for pointer, count and view; save takes priority over browse.
    always_comb begin
        w_save       = r_ev[0] & active;
        w_browse     = r_ev[1] & (r_count != {CW{1'b0}});
        w_wr_ptr_nxt = r_wr_ptr;
        w_count_nxt  = r_count;
        w_view_nxt   = r_view;
        if (w_save) begin
            w_wr_ptr_nxt = (r_wr_ptr == PW'(DEPTH - 1)) ? {PW{1'b0}} : r_wr_ptr + PW'(1);
            w_count_nxt  = (r_count == CW'(DEPTH)) ? r_count : r_count + CW'(1);
            w_view_nxt   = {CW{1'b0}};
        end else if (w_browse) begin
            w_view_nxt = (r_view == r_count - CW'(1)) ? {CW{1'b0}} : r_view + CW'(1);
        end else begin
            w_view_nxt = r_view;
        end
    end

    // Control state registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_ptr <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
            r_view   <= {CW{1'b0}};
            r_full   <= 1'b0;
            r_saved  <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_count  <= w_count_nxt;
            r_view   <= w_view_nxt;
            r_full   <= (w_count_nxt == CW'(DEPTH));
            r_saved  <= w_save;
        end
    end

    // Lap storage; contents are unreachable until written, so no reset.
    always_ff @(posedge CLK) begin
        if (w_save && !RST) begin
            r_mem[w_slot_wr()] <= in;
        end else begin
            r_mem <= r_mem;
        end
    end

    function automatic logic [PW-1:0] w_slot_wr();
        return r_wr_ptr;
    endfunction

    assign w_slot = f_slot(r_wr_ptr, r_view);

`ifdef LAP_SPLIT_EN
    logic [PW-1:0] w_slot_older;
    assign w_slot_older = (w_slot == {PW{1'b0}}) ? PW'(DEPTH - 1) : w_slot - PW'(1);
`endif

    // Registered read stage for the viewed lap and its split.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_lap   <= {WIDTH{1'b0}};
            r_split <= {WIDTH{1'b0}};
        end else if (r_count == {CW{1'b0}}) begin
            r_lap   <= {WIDTH{1'b0}};
            r_split <= {WIDTH{1'b0}};
        end else begin
            r_lap <= r_mem[w_slot];
`ifdef LAP_SPLIT_EN
            r_split <= (r_view == r_count - CW'(1)) ? r_mem[w_slot]
                                                     : r_mem[w_slot] - r_mem[w_slot_older];
`else
            r_split <= {WIDTH{1'b0}};
`endif
        end
    end

    assign lap_out   = r_lap;
    assign split_out = r_split;
    assign view_idx  = r_view;
    assign count     = r_count;
    assign full      = r_full;
    assign saved     = r_saved;
endmodule

// File: tb/tb_lap_memory.sv
// Randomized and directed bench for lap_memory against a queue-based lap model.
module tb_lap_memory;
    localparam int WIDTH = 32;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             active = 1'b1;
    logic [1:0]       KEY = 2'b11;
    logic [WIDTH-1:0] tb_in = '0;
    logic [WIDTH-1:0] lap_out, split_out;
    logic [CW-1:0]    view_idx, count;
    logic             full, saved;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    lap_memory #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .active(active), .KEY(KEY), .in(tb_in),
        .lap_out(lap_out), .split_out(split_out), .view_idx(view_idx),
        .count(count), .full(full), .saved(saved)
    );

    always #5 CLK = ~CLK;

    // Reference model: laps[0] is the newest lap.
    logic [WIDTH-1:0] laps[$];
    int               m_view = 0;
    bit               m_saved = 1'b0;
    logic [WIDTH-1:0] m_lap = '0;
    logic [WIDTH-1:0] m_split = '0;
    int               since_rst = 0;
    logic [1:0]       h1 = 2'b11, h2 = 2'b11, h3 = 2'b11, h4 = 2'b11;

    function automatic logic [WIDTH-1:0] split_of(int v);
`ifdef LAP_SPLIT_EN
        if (laps.size() == 0) return '0;
        if (v == laps.size() - 1) return laps[v];
        return laps[v] - laps[v + 1];
`else
        return '0;
`endif
    endfunction

    // A press acts three edges after the key is first sampled low, provided it was
    // sampled released just before and that earlier sample came after reset.
    always @(posedge CLK) begin
        bit sv, br;
        if (RST) begin
            laps.delete();
            m_view = 0; m_saved = 1'b0; m_lap = '0; m_split = '0; since_rst = 0;
        end else begin
            m_lap   = (laps.size() != 0) ? laps[m_view] : '0;
            m_split = split_of(m_view);
            if (since_rst < 100) since_rst++;
            sv = (since_rst >= 5) && h4[0] && !h3[0] && active;
            br = (since_rst >= 5) && h4[1] && !h3[1] && (laps.size() != 0);
            m_saved = sv;
            if (sv) begin
                laps.push_front(tb_in);
                if (laps.size() > DEPTH) void'(laps.pop_back());
                m_view = 0;
            end else if (br) begin
                m_view = (m_view + 1 == laps.size()) ? 0 : m_view + 1;
            end
        end
        h4 = h3; h3 = h2; h2 = h1; h1 = KEY;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge CLK) begin
        if (chk_en) begin
            chk("count", count, laps.size());
            chk("view_idx", view_idx, m_view);
            chk("full", full, laps.size() == DEPTH);
            chk("saved", saved, m_saved);
            chk("lap_out", lap_out, m_lap);
            chk("split_out", split_out, m_split);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic do_reset();
        @(negedge CLK); RST = 1'b1; KEY = 2'b11;
        cyc(3); RST = 1'b0; cyc(4);
    endtask

    task automatic press(input logic [1:0] mask);
        @(negedge CLK); KEY = ~mask;
        @(negedge CLK); KEY = 2'b11;
        cyc(6);
    endtask

    task automatic save(input logic [WIDTH-1:0] v);
        tb_in = v; active = 1'b1;
        press(2'b01);
    endtask

    initial begin
        logic [WIDTH-1:0] e_split [3];
        cyc(2);
        do_reset();
        chk_en = 1'b1;

        // Reset state and browse on empty store
        chk("rst_count", count, 0);
        chk("rst_lap", lap_out, 0);
        chk("rst_full", full, 0);
        press(2'b10);
        chk("empty_browse_view", view_idx, 0);
        chk("empty_browse_count", count, 0);

        // Three saves then browse with wrap
`ifdef LAP_SPLIT_EN
        e_split[0] = 225; e_split[1] = 150; e_split[2] = 100;
`else
        e_split[0] = 0; e_split[1] = 0; e_split[2] = 0;
`endif
        save(100); save(250); save(475);
        chk("three_count", count, 3);
        chk("three_lap", lap_out, 475);
        chk("three_split", split_out, e_split[0]);
        press(2'b10);
        chk("browse1_lap", lap_out, 250);
        chk("browse1_split", split_out, e_split[1]);
        press(2'b10);
        chk("browse2_lap", lap_out, 100);
        chk("browse2_split", split_out, e_split[2]);
        press(2'b10);
        chk("browse_wrap_lap", lap_out, 475);
        chk("browse_wrap_view", view_idx, 0);

        // Overflow: nine saves into eight slots
        do_reset();
        for (int i = 1; i <= 9; i++) save(i);
        chk("ovf_count", count, 8);
        chk("ovf_full", full, 1);
        chk("ovf_lap0", lap_out, 9);
        for (int i = 8; i >= 2; i--) begin
            press(2'b10);
            chk("ovf_browse", lap_out, i);
        end
        press(2'b10);
        chk("ovf_wrap", lap_out, 9);

        // Inactive save is discarded
        tb_in = 42; active = 1'b0;
        press(2'b01);
        chk("inactive_count", count, 8);
        chk("inactive_lap", lap_out, 9);
        active = 1'b1;

        // Simultaneous events with view 2: save wins
        press(2'b10); press(2'b10);
        chk("sim_pre_view", view_idx, 2);
        tb_in = 777;
        press(2'b11);
        chk("sim_view", view_idx, 0);
        chk("sim_lap", lap_out, 777);

        // Button held through reset release
        @(negedge CLK); RST = 1'b1; KEY = 2'b10;
        cyc(3); RST = 1'b0; cyc(8);
        chk("held_count", count, 0);
        KEY = 2'b11; cyc(3);
        save(55);
        chk("held_after_count", count, 1);
        chk("held_after_lap", lap_out, 55);

        // Events one cycle apart are both honoured
        tb_in = 66;
        @(negedge CLK); KEY = 2'b10;
        @(negedge CLK); KEY = 2'b11;
        @(negedge CLK); KEY = 2'b10;
        @(negedge CLK); KEY = 2'b11;
        cyc(6);
        chk("backtoback_count", count, 3);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            KEY[0] = ($urandom_range(0, 3) != 0);
            KEY[1] = ($urandom_range(0, 2) != 0);
            active = ($urandom_range(0, 7) != 0);
            tb_in  = $urandom;
            RST    = ($urandom_range(0, 399) == 0);
        end
        RST = 1'b0; KEY = 2'b11;
        cyc(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
